vga_timing_monitor: RTL and testbench

//  Sink-side checker for the 12-bit RGB + hs/vs VGA output of the video generator.

---
 rtl/vga_timing_monitor.sv | 231 +++++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
// Sink-side VGA timing checker: measures line/frame totals and sync widths, tracks the active pixel.
// Define VGA_MON_CRC_EN to add a per-frame CRC-16-CCITT of the active pixels on frame_crc.
module vga_timing_monitor #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_START  = 144,
  parameter int unsigned V_START  = 35,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic [11:0] h_total,
  output logic [10:0] v_total,
  output logic [11:0] hs_width,
  output logic [10:0] vs_width,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_crc
);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_e;

  localparam logic [11:0] H_LO = 12'(H_START);
  localparam logic [11:0] H_HI = 12'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO = 11'(V_START);
  localparam logic [10:0] V_HI = 11'(V_START + V_ACTIVE);

  state_e      state_q, state_d;
  logic        hs_in_q, vs_in_q, hs_prev_q, vs_prev_q;
  logic [11:0] rgb_q;
  logic [11:0] count_h_q, count_h_d;
  logic [10:0] count_v_q, count_v_d;
  logic [11:0] hsw_cnt_q, hsw_cnt_d;
  logic [10:0] vsw_cnt_q, vsw_cnt_d;
  logic [11:0] h_total_q, h_total_d, snap_h_q, snap_h_d;
  logic [10:0] v_total_q, v_total_d, snap_v_q, snap_v_d;
  logic [11:0] hs_width_q, hs_width_d;
  logic [10:0] vs_width_q, vs_width_d;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        locked_q, locked_d, frame_done_q, frame_done_d;

  logic hs_act, hs_prev_act, vs_act, vs_prev_act;
  logic hs_lead, hs_trail, vs_lead, vs_trail;
  logic h_sat, in_win, totals_match;

  always_comb begin
    hs_act      = (hs_in_q == HS_POL);
    hs_prev_act = (hs_prev_q == HS_POL);
    vs_act      = (vs_in_q == VS_POL);
    vs_prev_act = (vs_prev_q == VS_POL);
    hs_lead     = hs_act & ~hs_prev_act;
    hs_trail    = ~hs_act & hs_prev_act;
    vs_lead     = vs_act & ~vs_prev_act;
    vs_trail    = ~vs_act & vs_prev_act;
    h_sat       = (count_h_q == '1);
  end

  always_comb begin
    count_h_d    = h_sat ? count_h_q : count_h_q + 12'd1;
    count_v_d    = count_v_q;
    h_total_d    = h_total_q;
    v_total_d    = v_total_q;
    hs_width_d   = hs_width_q;
    vs_width_d   = vs_width_q;
    snap_h_d     = snap_h_q;
    snap_v_d     = snap_v_q;
    state_d      = state_q;
    frame_done_d = 1'b0;

    if (hs_lead) begin
      h_total_d = h_sat ? count_h_q : count_h_q + 12'd1;
      count_h_d = '0;
      count_v_d = (count_v_q == '1) ? count_v_q : count_v_q + 11'd1;
    end
    if (vs_lead) begin
      v_total_d = (count_v_q == '1) ? count_v_q : count_v_q + 11'd1;
      count_v_d = '0;
    end

    hsw_cnt_d = hs_act ? ((hsw_cnt_q == '1) ? hsw_cnt_q : hsw_cnt_q + 12'd1) : '0;
    if (hs_trail) hs_width_d = hsw_cnt_q;

    vsw_cnt_d = '0;
    if (vs_act) vsw_cnt_d = (hs_lead && vsw_cnt_q != '1) ? vsw_cnt_q + 11'd1 : vsw_cnt_q;
    if (vs_trail) vs_width_d = vsw_cnt_q;

    // Compare against the totals being captured this cycle, so a coincident hs edge counts.
    totals_match = (h_total_d == snap_h_q) && (v_total_d == snap_v_q);
    if (vs_lead) begin
      snap_h_d = h_total_d;
      snap_v_d = v_total_d;
    end

    unique case (state_q)
      ST_SEARCH: if (vs_lead) state_d = ST_MEASURE;
      ST_MEASURE: if (vs_lead) begin
        frame_done_d = 1'b1;
        if (totals_match) state_d = ST_LOCKED;
      end
      ST_LOCKED: if (vs_lead) begin
        frame_done_d = 1'b1;
        if (!totals_match) state_d = ST_MEASURE;
      end
      default: state_d = ST_SEARCH;
    endcase

    if (h_sat) begin
      state_d      = ST_SEARCH;
      frame_done_d = 1'b0;
    end
    locked_d = (state_d == ST_LOCKED);

    in_win = (count_h_q >= H_LO) && (count_h_q < H_HI) &&
             (count_v_q >= V_LO) && (count_v_q < V_HI);
    pix_valid_d = in_win;
    pix_x_d     = in_win ? 10'(count_h_q - H_LO) : '0;
    pix_y_d     = in_win ? 10'(count_v_q - V_LO) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SEARCH;
      hs_in_q      <= 1'b0;
      vs_in_q      <= 1'b0;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      rgb_q        <= '0;
      count_h_q    <= '0;
      count_v_q    <= '0;
      hsw_cnt_q    <= '0;
      vsw_cnt_q    <= '0;
      h_total_q    <= '0;
      v_total_q    <= '0;
      snap_h_q     <= '0;
      snap_v_q     <= '0;
      hs_width_q   <= '0;
      vs_width_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_in_q      <= hs;
      vs_in_q      <= vs;
      hs_prev_q    <= hs_in_q;
      vs_prev_q    <= vs_in_q;
      rgb_q        <= {r, g, b};
      count_h_q    <= count_h_d;
      count_v_q    <= count_v_d;
      hsw_cnt_q    <= hsw_cnt_d;
      vsw_cnt_q    <= vsw_cnt_d;
      h_total_q    <= h_total_d;
      v_total_q    <= v_total_d;
      snap_h_q     <= snap_h_d;
      snap_v_q     <= snap_v_d;
      hs_width_q   <= hs_width_d;
      vs_width_q   <= vs_width_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign h_total    = h_total_q;
  assign v_total    = v_total_q;
  assign hs_width   = hs_width_q;
  assign vs_width   = vs_width_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;

`ifdef VGA_MON_CRC_EN
  logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] x;
    logic        fb;
    x = c;
    for (int unsigned i = 0; i < 12; i++) begin
      fb = x[15] ^ d[4'(11 - i)];
      x  = {x[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return x;
  endfunction

  // pix_valid_q and rgb_q were captured on the same edge, so they describe the same pixel.
  always_comb begin
    crc_d       = crc_q;
    frame_crc_d = frame_crc_q;
    if (vs_lead) begin
      frame_crc_d = crc_q;
      crc_d       = '1;
    end else if (pix_valid_q) begin
      crc_d = crc_step(crc_q, rgb_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q       <= '1;
      frame_crc_q <= '0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^rgb_q;
  assign frame_crc  = '0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a reduced 24x12 raster with a pixel scoreboard.
`timescale 1ns/1ps
module tb_vga_timing_monitor;

  localparam int H_ACT = 16;
  localparam int V_ACT = 8;
  localparam int H_ST  = 5;
  localparam int V_ST  = 3;
  localparam int H_TOT = 24;
  localparam int V_TOT = 12;
  localparam int HSW   = 2;
  localparam int VSW   = 2;
  localparam int PIX_PER_FRAME = H_ACT * V_ACT;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs, vs;
  logic [3:0]  r, g, b;
  logic [11:0] h_total;
  logic [10:0] v_total;
  logic [11:0] hs_width;
  logic [10:0] vs_width;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic        locked, frame_done;
  logic [15:0] frame_crc;

  always #5 clk = ~clk;

  vga_timing_monitor #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_START(H_ST), .V_START(V_ST),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .h_total(h_total), .v_total(v_total), .hs_width(hs_width), .vs_width(vs_width),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .locked(locked), .frame_done(frame_done), .frame_crc(frame_crc)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int unsigned stamp; int x; int y;} exp_t;
  exp_t sb[$];
  exp_t e;
  int   pix_total = 0;
  int   fd_count  = 0;
  logic fd_locked [0:63];
  logic mon_en = 1'b0;
  int   nframes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] x;
    x = c ^ {d, 4'h0};
    for (int k = 0; k < 12; k++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
    return x;
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (pix_valid) begin
        pix_total++;
        chk("pix_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pix_time", cyc, e.stamp);
          chk("pix_x", 32'(pix_x), e.x);
          chk("pix_y", 32'(pix_y), e.y);
        end
      end else if (sb.size() != 0 && sb[0].stamp < cyc) begin
        e = sb.pop_front();
        chk("pix_valid_due", 32'(pix_valid), 32'd1);
      end
      if (frame_done) begin
        if (fd_count < 64) fd_locked[fd_count] = locked;
        fd_count++;
      end
    end
  end

  // Raw inputs pass an input register and a count restart, so count_h trails the raw column by 2.
  task automatic step(input logic h, input logic v, input int hc, input int vc, input bit in_frame);
    @(posedge clk);
    #1;
    hs = h;
    vs = v;
    {r, g, b} = 12'hFFF;
    if (in_frame && hc >= H_ST + 2 && hc < H_ST + 2 + H_ACT && vc >= V_ST && vc < V_ST + V_ACT)
      sb.push_back('{cyc + 1, hc - H_ST - 2, vc - V_ST});
  endtask

  task automatic drive_lines(input int extra_last, input int nlines);
    for (int vc = 0; vc < nlines; vc++)
      for (int hc = 0; hc < H_TOT + ((vc == V_TOT - 1) ? extra_last : 0); hc++)
        step((hc < HSW) ? 1'b0 : 1'b1, (vc < VSW) ? 1'b0 : 1'b1, hc, vc, 1'b1);
  endtask

  task automatic frame(input int extra_last);
    drive_lines(extra_last, V_TOT);
    nframes++;
    chk("pix_count", pix_total, nframes * PIX_PER_FRAME);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 0, 0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] crc_exp;
    rst = 1'b1; hs = 1'b1; vs = 1'b1; {r, g, b} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_h_total", 32'(h_total), 0);
    chk("rst_v_total", 32'(v_total), 0);
    chk("rst_hs_width", 32'(hs_width), 0);
    chk("rst_vs_width", 32'(vs_width), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_pix_x", 32'(pix_x), 0);
    chk("rst_pix_y", 32'(pix_y), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_crc", 32'(frame_crc), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_outputs",
        {h_total, v_total, hs_width, vs_width, pix_valid, pix_x, pix_y, locked, frame_done}, 0);
    chk("post_rst_frame_crc", 32'(frame_crc), 0);

    mon_en = 1'b1;
    idle(5);
    frame(0); frame(0); frame(0);
    chk("h_total", 32'(h_total), H_TOT);
    chk("v_total", 32'(v_total), V_TOT);
    chk("hs_width", 32'(hs_width), HSW);
    chk("vs_width", 32'(vs_width), VSW);
    chk("fd_count_3", fd_count, 2);
    chk("fd1_locked", 32'(fd_locked[0]), 0);
    chk("fd2_locked", 32'(fd_locked[1]), 1);
    chk("locked_3", 32'(locked), 1);
`ifdef VGA_MON_CRC_EN
    crc_exp = 16'hFFFF;
    for (int i = 0; i < PIX_PER_FRAME; i++) crc_exp = ref_crc(crc_exp, 12'hFFF);
`else
    crc_exp = 16'h0000;
`endif
    chk("frame_crc", 32'(frame_crc), 32'(crc_exp));

    frame(1);
    frame(0);
    chk("fd_count_5", fd_count, 4);
    chk("long_line_fd_locked", 32'(fd_locked[3]), 0);
    chk("long_line_locked", 32'(locked), 0);
    frame(0);
    chk("clean1_fd_locked", 32'(fd_locked[4]), 0);
    frame(0);
    chk("clean2_fd_locked", 32'(fd_locked[5]), 1);
    chk("relock", 32'(locked), 1);

    idle(4200);
    chk("sat_locked", 32'(locked), 0);
    chk("sat_fd_silent", fd_count, 6);
    for (int hc = 0; hc < H_TOT; hc++) step((hc < HSW) ? 1'b0 : 1'b1, 1'b1, hc, 0, 1'b0);
    frame(0);
    chk("search_fd_silent", fd_count, 6);
    chk("search_locked", 32'(locked), 0);
    frame(0);
    chk("reacq_fd_locked", 32'(fd_locked[6]), 0);
    frame(0);
    chk("reacq_fd_count", fd_count, 8);
    chk("reacq_locked", 32'(locked), 1);

    drive_lines(0, 2);
    rst = 1'b1;
    #1;
    chk("midrst_h_total", 32'(h_total), 0);
    chk("midrst_v_total", 32'(v_total), 0);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_hs_width", 32'(hs_width), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
    frame(0); frame(0); frame(0);
    chk("post_midrst_fd_count", fd_count, 11);
    chk("post_midrst_locked", 32'(locked), 1);
    idle(4);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
